// File: rtl/ijtag_pkg.sv
// ijtag_pkg: scan state encoding and sizing helpers shared by the IJTAG scan driver files
package ijtag_pkg;
    typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, UPDATE, DONE} scan_state_e;
    localparam int MAX_LEN_DEF = 64;
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction
endpackage

// File: rtl/ijtag_scan_driver_if.sv
// ijtag_scan_driver_if: host request/response and IJTAG network lines of the scan driver
interface ijtag_scan_driver_if
    import ijtag_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W = len_w(MAX_LEN)
);
    logic               Start;
    logic [LEN_W-1:0]   Len;
    logic [MAX_LEN-1:0] DataIn;
    logic               Busy;
    logic               Done;
    logic               Error;
    logic [MAX_LEN-1:0] DataOut;
    logic               Select;
    logic               CaptureEN;
    logic               ShiftEN;
    logic               UpdateEn;
    logic               SI;
    logic               SO;
    modport master (
        input  Start, Len, DataIn, SO,
        output Busy, Done, Error, DataOut, Select, CaptureEN, ShiftEN, UpdateEn, SI
    );
    modport slave (
        output Start, Len, DataIn, SO,
        input  Busy, Done, Error, DataOut, Select, CaptureEN, ShiftEN, UpdateEn, SI
    );
endinterface

// File: rtl/ijtag_scan_driver.sv
// ijtag_scan_driver: runs one capture/shift/update scan on an IJTAG network per host request
module ijtag_scan_driver
    import ijtag_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W = len_w(MAX_LEN)
) (
    input logic Clock,
    input logic Rst,
    ijtag_scan_driver_if.master bus
);
    scan_state_e        state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d;
    logic [MAX_LEN-1:0] data_q, data_d, dout_q, dout_d, sh;
    logic               err_q, err_d;
    logic               select_q, select_d, capture_en_q, capture_en_d;
    logic               shift_en_q, shift_en_d, update_en_q, update_en_d;
    logic               si_q, si_d, busy_q, busy_d, done_q, done_d, error_q, error_d;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        data_d  = data_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.Start) begin
                len_d   = bus.Len;
                data_d  = bus.DataIn;
                dout_d  = '0;
                cnt_d   = '0;
                err_d   = (bus.Len == '0) || (bus.Len > LEN_W'(MAX_LEN));
                state_d = err_d ? DONE : CAPTURE;
            end
            CAPTURE: state_d = SHIFT;
            SHIFT: begin
                dout_d  = dout_q | (MAX_LEN'(bus.SO) << cnt_q);
                cnt_d   = cnt_q + LEN_W'(1);
                // compare against Len-1 so a full MAX_LEN scan never depends on a wrapped count
                state_d = (cnt_q == len_q - LEN_W'(1)) ? UPDATE : SHIFT;
            end
            UPDATE:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // outputs are decoded from the next state so they come straight off flops aligned with state_q
        sh           = data_d >> cnt_d;
        select_d     = (state_d == CAPTURE) || (state_d == SHIFT) || (state_d == UPDATE);
        capture_en_d = state_d == CAPTURE;
        shift_en_d   = state_d == SHIFT;
        update_en_d  = state_d == UPDATE;
        si_d         = shift_en_d && sh[0];
        busy_d       = state_d != IDLE;
        done_d       = state_d == DONE;
        error_d      = done_d && err_d;
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            dout_q       <= '0;
            err_q        <= 1'b0;
            select_q     <= 1'b0;
            capture_en_q <= 1'b0;
            shift_en_q   <= 1'b0;
            update_en_q  <= 1'b0;
            si_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            dout_q       <= dout_d;
            err_q        <= err_d;
            select_q     <= select_d;
            capture_en_q <= capture_en_d;
            shift_en_q   <= shift_en_d;
            update_en_q  <= update_en_d;
            si_q         <= si_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.Select    = select_q;
    assign bus.CaptureEN = capture_en_q;
    assign bus.ShiftEN   = shift_en_q;
    assign bus.UpdateEn  = update_en_q;
    assign bus.SI        = si_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Error     = error_q;
    assign bus.DataOut   = dout_q;
endmodule

// File: tb/tb_ijtag_scan_driver.sv
// tb_ijtag_scan_driver: scoreboard bench with loopback, register and locking-SIB network models
module tb_ijtag_scan_driver;
    import ijtag_pkg::*;
    localparam int ML = 64;
    localparam int LW = len_w(ML);

    typedef struct {
        logic [63:0] dout;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ijtag_scan_driver_if #(.MAX_LEN(ML), .LEN_W(LW)) bus();
    ijtag_scan_driver #(.MAX_LEN(ML), .LEN_W(LW)) dut (.Clock(clk), .Rst(rst), .bus(bus));

    int total = 0;
    int bad = 0;
    exp_t sb[$];
    exp_t e;
    int n_sel = 0, n_cap = 0, n_shift = 0, n_upd = 0, n_busy = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // network models: 1-flop loopback, 8-bit capture/update register, locking SIB
    logic [1:0] mode = 2'd0;
    logic       comp_out = 1'b0;
    logic       lb, sib_sr, sib_req, sib_open;
    logic [7:0] sr, upd;
    always @(posedge clk) begin
        if (rst) begin
            lb <= 1'b0; sr <= 8'h0; upd <= 8'h0;
            sib_sr <= 1'b0; sib_req <= 1'b0; sib_open <= 1'b0;
        end else begin
            if (bus.CaptureEN) begin
                lb <= 1'b0; sr <= 8'hA5; sib_sr <= sib_open;
            end else if (bus.ShiftEN) begin
                lb <= bus.SI; sr <= {bus.SI, sr[7:1]}; sib_sr <= bus.SI;
            end
            if (bus.UpdateEn) begin
                upd <= sr;
                sib_req <= sib_sr;
                sib_open <= sib_open | (sib_req & sib_sr & comp_out);
            end
        end
    end
    assign bus.SO = (mode == 2'd0) ? lb : (mode == 2'd1) ? sr[0] : sib_sr;

    always @(negedge clk) begin
        n_sel   += int'(bus.Select);
        n_cap   += int'(bus.CaptureEN);
        n_shift += int'(bus.ShiftEN);
        n_upd   += int'(bus.UpdateEn);
        n_busy  += int'(bus.Busy);
        chk("si_gate", 64'(bus.SI & ~bus.ShiftEN), 64'd0);
        chk("sel_decode", 64'(bus.Select), 64'(bus.CaptureEN | bus.ShiftEN | bus.UpdateEn));
        chk("err_wo_done", 64'(bus.Error & ~bus.Done), 64'd0);
        if (bus.Done) begin
            if (sb.size() == 0) chk("sb_empty", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                chk("dout", bus.DataOut, e.dout);
                chk("err", 64'(bus.Error), 64'(e.err));
            end
        end
    end

    // poke: 1 = Start pulse mid-SHIFT, 2 = Start pulse in the DONE cycle
    task automatic scan(input logic [LW-1:0] len, input logic [63:0] din, input logic [63:0] exp_dout,
                        input logic exp_err, input int poke, output int cyc, output int nb);
        int b0;
        @(posedge clk); #1;
        bus.Start = 1'b1; bus.Len = len; bus.DataIn = din;
        sb.push_back('{dout: exp_dout, err: exp_err});
        @(posedge clk); #1;
        bus.Start = 1'b0;
        b0 = n_busy;
        cyc = 1;
        while (!bus.Done && cyc < 300) begin
            if (poke == 1 && cyc == 4) begin
                bus.Start = 1'b1; bus.Len = LW'(2); bus.DataIn = '1;
            end
            @(posedge clk); #1;
            bus.Start = 1'b0;
            cyc++;
        end
        if (!bus.Done) chk("done_timeout", 64'd1, 64'd0);
        if (poke == 2) begin
            bus.Start = 1'b1;
            @(posedge clk); #1;
            bus.Start = 1'b0;
            chk("done_start_ign", 64'(bus.Busy), 64'd0);
        end else begin
            @(negedge clk); #1;
        end
        nb = n_busy - b0;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    initial begin
        int cyc, nb, c0, s0, u0, l0;
        logic [63:0] din;
        bus.Start = 1'b0; bus.Len = '0; bus.DataIn = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 64'({bus.Select, bus.CaptureEN, bus.ShiftEN, bus.UpdateEn,
                               bus.SI, bus.Busy, bus.Done, bus.Error}), 64'd0);
        chk("reset_dout", bus.DataOut, 64'd0);
        rst = 1'b0;

        c0 = n_cap; s0 = n_shift; u0 = n_upd;
        scan(LW'(8), 64'h3C, 64'h78, 1'b0, 0, cyc, nb);
        chk("lb_done_cyc", 64'(cyc), 64'd11);
        chk("lb_busy", 64'(nb), 64'd11);
        chk("lb_ncap", 64'(n_cap - c0), 64'd1);
        chk("lb_nshift", 64'(n_shift - s0), 64'd8);
        chk("lb_nupd", 64'(n_upd - u0), 64'd1);

        mode = 2'd1;
        scan(LW'(8), 64'h5A, 64'hA5, 1'b0, 0, cyc, nb);
        chk("reg_update", 64'(upd), 64'h5A);

        mode = 2'd2;
        for (int c = 1; c >= 0; c--) begin
            comp_out = c[0];
            pulse_rst();
            scan(LW'(1), 64'h1, 64'h0, 1'b0, 0, cyc, nb);
            chk("sib_first", 64'(sib_open), 64'd0);
            scan(LW'(1), 64'h1, 64'h0, 1'b0, 0, cyc, nb);
            chk("sib_second", 64'(sib_open), 64'(c[0]));
        end

        mode = 2'd0;
        for (int i = 0; i < 2; i++) begin
            l0 = n_sel;
            scan((i == 0) ? LW'(0) : LW'(ML + 1), '1, 64'h0, 1'b1, 0, cyc, nb);
            chk("rej_done_cyc", 64'(cyc), 64'd1);
            chk("rej_busy", 64'(nb), 64'd1);
            chk("rej_no_sel", 64'(n_sel - l0), 64'd0);
        end

        din = {$urandom, $urandom};
        scan(LW'(ML), din, din << 1, 1'b0, 0, cyc, nb);
        chk("max_busy", 64'(nb), 64'(ML + 3));

        scan(LW'(8), 64'hC3, 64'h86, 1'b0, 1, cyc, nb);
        chk("poke_shift_busy", 64'(nb), 64'd11);
        scan(LW'(8), 64'h81, 64'h02, 1'b0, 2, cyc, nb);
        repeat (3) @(posedge clk);
        #1;
        chk("poke_done_idle", 64'(bus.Busy), 64'd0);

        u0 = n_upd;
        @(posedge clk); #1;
        bus.Start = 1'b1; bus.Len = LW'(8); bus.DataIn = 64'hFF;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_shift", 64'(bus.ShiftEN), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_outs", 64'({bus.Select, bus.CaptureEN, bus.ShiftEN, bus.UpdateEn,
                             bus.SI, bus.Busy, bus.Done, bus.Error}), 64'd0);
        chk("rst_dout", bus.DataOut, 64'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_upd", 64'(n_upd - u0), 64'd0);
        scan(LW'(8), 64'h3C, 64'h78, 1'b0, 0, cyc, nb);
        chk("post_rst_busy", 64'(nb), 64'd11);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
